gelu_act_buffer: RTL and testbench

Ping-pong activation buffer sitting directly downstream of `mm_gelu`. It captures each int8 GELU output tile (M1×M3 elements, closed by tlast) into one of two banks and replays it as a sign-extended 32-bit stream that feeds the A input of the following FFN matmul. Capture of tile k+1 overlaps replay of tile k, so `mm_gelu` never waits for the downstream matmul's full tile time.

---
 rtl/gelu_act_buffer.sv | 191 +++++++++++++++++++
 tb/tb_gelu_act_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelu_act_buffer.sv
// gelu_act_buffer: ping-pong int8 tile buffer, replays as sign-extended stream.
// Optional: define GELU_BUF_REPLAY_EN to stream each bank REPLAY times.
module gelu_act_buffer #(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 32,
  parameter int DEPTH   = 98304,
  parameter int REPLAY  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_W-1:0]     in_tdata,
  input  logic               in_tvalid,
  input  logic               in_tlast,
  output logic               in_tready,
  output logic [D_W_ACC-1:0] out_tdata,
  output logic               out_tvalid,
  output logic               out_tlast,
  input  logic               out_tready,
  output logic [1:0]         bank_full,
  output logic               overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (REPLAY < 1) begin : g_chk_rep
    $error("REPLAY must be at least 1");
  end
  if (D_W_ACC <= D_W) begin : g_chk_w
    $error("D_W_ACC must exceed D_W");
  end

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILL,
    B_FULL,
    B_DRAIN
  } bank_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PRIME,
    R_STREAM
  } rd_e;

  bank_e          st [2];
  logic [AW-1:0]  last_idx [2];
  logic           wr_sel;
  logic           rd_sel;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  ra;
  logic [AW-1:0]  raddr;
  logic [D_W-1:0] mem0 [DEPTH];
  logic [D_W-1:0] mem1 [DEPTH];
  logic [D_W-1:0] q;
  rd_e            fsm;
  logic           issued_all;

  logic in_fire;
  logic close;
  logic out_fire;
  logic pass_end;
  logic final_pass;
  logic rep_pend;
  logic start;
  logic re;
  logic rlast;

  assign in_tready = (st[wr_sel] == B_EMPTY) ||
                     (st[wr_sel] == B_FILL);
  assign in_fire   = in_tvalid && in_tready;
  assign close     = in_fire &&
                     (in_tlast || wr_addr == AW'(DEPTH - 1));

  assign out_fire  = out_tvalid && out_tready;
  assign pass_end  = out_fire && out_tlast;

  // A pass starts from IDLE on a freshly filled bank or a pending replay.
  assign start = (fsm == R_IDLE) &&
                 (st[rd_sel] == B_FULL || rep_pend);
  assign re    = start ||
                 (fsm != R_IDLE && !issued_all &&
                  (!out_tvalid || out_tready));
  assign raddr = start ? '0 : ra;
  assign rlast = (raddr == last_idx[rd_sel]);

  assign out_tdata = {{(D_W_ACC - D_W){q[D_W-1]}}, q};
  assign bank_full = {st[1][1], st[0][1]};

`ifdef GELU_BUF_REPLAY_EN
  localparam int PW = (REPLAY > 1) ? $clog2(REPLAY) : 1;
  logic [PW-1:0] pass;

  assign final_pass = (pass == PW'(REPLAY - 1));

  // Count passes over the draining bank; request a restart between passes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass     <= '0;
      rep_pend <= 1'b0;
    end else begin
      if (start) rep_pend <= 1'b0;
      if (pass_end) begin
        if (final_pass) begin
          pass <= '0;
        end else begin
          pass     <= pass + 1'b1;
          rep_pend <= 1'b1;
        end
      end
    end
  end
`else
  assign final_pass = 1'b1;
  assign rep_pend   = 1'b0;
`endif

  // Tile storage; memory is never reset, only bank states guard its use.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (wr_sel) mem1[wr_addr] <= in_tdata;
      else        mem0[wr_addr] <= in_tdata;
    end
  end

  // Bank states, write pointer and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        st[i]       <= B_EMPTY;
        last_idx[i] <= '0;
      end
      wr_sel   <= 1'b0;
      wr_addr  <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_fire) begin
        if (close) begin
          st[wr_sel]       <= B_FULL;
          last_idx[wr_sel] <= wr_addr;
          wr_sel           <= ~wr_sel;
          wr_addr          <= '0;
          if (!in_tlast) overflow <= 1'b1;
        end else begin
          st[wr_sel] <= B_FILL;
          wr_addr    <= wr_addr + AW'(1);
        end
      end
      if (start) st[rd_sel] <= B_DRAIN;
      if (pass_end && final_pass) st[rd_sel] <= B_EMPTY;
    end
  end

  // Read sequencer: issue addresses whenever the output slot frees up.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= R_IDLE;
      rd_sel     <= 1'b0;
      ra         <= '0;
      issued_all <= 1'b0;
    end else begin
      if (re) begin
        ra         <= raddr + AW'(1);
        issued_all <= rlast;
      end
      case (fsm)
        R_IDLE:   if (start) fsm <= R_PRIME;
        R_PRIME:  fsm <= pass_end ? R_IDLE : R_STREAM;
        R_STREAM: if (pass_end) fsm <= R_IDLE;
        default:  fsm <= R_IDLE;
      endcase
      if (pass_end && final_pass) rd_sel <= ~rd_sel;
    end
  end

  // Registered memory read doubles as the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else if (re) begin
      q          <= rd_sel ? mem1[raddr] : mem0[raddr];
      out_tvalid <= 1'b1;
      out_tlast  <= rlast;
    end else if (out_fire) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gelu_act_buffer.sv
// tb_gelu_act_buffer: directed vectors and corner sequences.
// Runs with DEPTH=16; expectations adapt to GELU_BUF_REPLAY_EN.
module tb_gelu_act_buffer;

  localparam int DEPTH = 16;
`ifdef GELU_BUF_REPLAY_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_tdata;
  logic        in_tvalid;
  logic        in_tlast;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tlast;
  logic        out_tready;
  logic [1:0]  bank_full;
  logic        overflow;

  always #5 clk = ~clk;

  gelu_act_buffer #(
    .D_W(8), .D_W_ACC(32), .DEPTH(DEPTH), .REPLAY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tlast(in_tlast), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tlast(out_tlast), .out_tready(out_tready),
    .bank_full(bank_full), .overflow(overflow)
  );

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic [31:0] e;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cyc = -1;

  logic [32:0] got_q[$];
  int          got_c[$];
  logic [32:0] exp_q[$];
  logic [32:0] tile_q[$];

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        pl = 1'b0;
  logic [31:0] pd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Output monitor: collect handshakes, check hold during stalls.
  always @(negedge clk) begin
    if (rst) begin
      pv <= 1'b0;
      pr <= 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 64'(out_tvalid), 64'd1);
        chk("hold_data", 64'(out_tdata), 64'(pd));
        chk("hold_last", 64'(out_tlast), 64'(pl));
      end
      if (out_tvalid && !pv && rise_cyc < 0) rise_cyc <= cyc;
      if (out_tvalid && out_tready) begin
        got_q.push_back({out_tlast, out_tdata});
        got_c.push_back(cyc);
      end
      pv <= out_tvalid;
      pr <= out_tready;
      pd <= out_tdata;
      pl <= out_tlast;
    end
  end

  task automatic send(input logic [7:0] d, input logic l,
                      output int hs);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    hs = -1;
    in_tdata = d;
    in_tlast = l;
    in_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_tready;
      if (acc) hs = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic expect_tile();
    for (int p = 0; p < NPASS; p++)
      foreach (tile_q[i]) exp_q.push_back(tile_q[i]);
    tile_q.delete();
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string nm);
    chk({nm, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size())
        chk($sformatf("%s[%0d]", nm, i),
            64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    got_c.delete();
    exp_q.delete();
  endtask

  vec_t tbl[11];
  int   hs;
  int   t_last;
  int   h3;

  initial begin
    tbl[0]  = '{8'h01, 1'b0, 32'h0000_0001};
    tbl[1]  = '{8'h02, 1'b0, 32'h0000_0002};
    tbl[2]  = '{8'h03, 1'b0, 32'h0000_0003};
    tbl[3]  = '{8'h04, 1'b0, 32'h0000_0004};
    tbl[4]  = '{8'h05, 1'b0, 32'h0000_0005};
    tbl[5]  = '{8'h06, 1'b0, 32'h0000_0006};
    tbl[6]  = '{8'h07, 1'b0, 32'h0000_0007};
    tbl[7]  = '{8'h08, 1'b1, 32'h0000_0008};
    tbl[8]  = '{8'h80, 1'b0, 32'hFFFF_FF80};
    tbl[9]  = '{8'hFF, 1'b0, 32'hFFFF_FFFF};
    tbl[10] = '{8'h7F, 1'b1, 32'h0000_007F};

    rst = 1'b1;
    in_tdata = '0;
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    out_tready = 1'b0;
    t_last = 0;
    h3 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_out_tlast", 64'(out_tlast), 64'd0);
    chk("rst_out_tdata", 64'(out_tdata), 64'd0);
    chk("rst_bank_full", 64'(bank_full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_in_tready", 64'(in_tready), 64'd1);
    rst = 1'b0;

    // Table: two tiles, sign extension, latency and bubble timing.
    out_tready = 1'b1;
    rise_cyc = -1;
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].d, tbl[i].l, hs);
      if (i == 7) t_last = hs;
      tile_q.push_back({tbl[i].l, tbl[i].e});
      if (tbl[i].l) expect_tile();
    end
    wait_out(11 * NPASS);
    chk("latency", 64'(rise_cyc), 64'(t_last + 2));
    if (got_c.size() >= 9) begin
      chk("no_gap", 64'(got_c[7] - got_c[0]), 64'd7);
      chk("bubble", 64'(got_c[8] - got_c[7]), 64'd2);
    end else begin
      chk("timing_count", 64'(got_c.size()), 64'd9);
    end
    check_stream("tbl");

    // Three tiles of 4 against a stalled consumer.
    out_tready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 4; i++) begin
        send(8'(8'h10 * (t + 1) + i), i == 3, hs);
        tile_q.push_back({i == 3, 32'(8'h10 * (t + 1) + i)});
      end
      expect_tile();
    end
    repeat (2) @(posedge clk);
    #1;
    chk("stall_in_tready", 64'(in_tready), 64'd0);
    chk("stall_bank_full", 64'(bank_full), 64'd3);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(8'(8'hF0 + i), i == 3, hs);
          if (i == 0) h3 = hs;
          tile_q.push_back({i == 3, 32'hFFFF_FF00 | 32'(8'hF0 + i)});
        end
        expect_tile();
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_tready = 1'b1;
      end
    join
    wait_out(12 * NPASS);
    if (got_c.size() >= 4 * NPASS)
      chk("resume", 64'(h3), 64'(got_c[4 * NPASS - 1] + 1));
    else
      chk("resume_count", 64'(got_c.size()), 64'(4 * NPASS));
    check_stream("order");

    // Full-depth tile with a randomly stalling consumer.
    fork
      begin
        logic [7:0] d;
        int hr;
        for (int i = 0; i < DEPTH; i++) begin
          d = 8'($urandom_range(0, 255));
          tile_q.push_back({i == DEPTH - 1, {{24{d[7]}}, d}});
          send(d, i == DEPTH - 1, hr);
        end
        expect_tile();
      end
      begin
        int k;
        k = 0;
        while (k < 3000 && got_q.size() < DEPTH * NPASS) begin
          @(posedge clk);
          #1;
          out_tready = 1'($urandom_range(0, 1));
          k++;
        end
      end
    join
    out_tready = 1'b1;
    wait_out(DEPTH * NPASS);
    chk("full_no_ovf", 64'(overflow), 64'd0);
    check_stream("rand");

    // Tile longer than a bank splits and flags overflow.
    for (int i = 0; i < 20; i++) begin
      send(8'(i + 1), i == 19, hs);
      tile_q.push_back({i == 15 || i == 19, 32'(i + 1)});
      if (i == 15 || i == 19) expect_tile();
    end
    wait_out(20 * NPASS);
    chk("ovf_flag", 64'(overflow), 64'd1);
    check_stream("ovf");

    // Reset mid-tile discards the partial tile.
    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b0, hs);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_bank_full", 64'(bank_full), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("mid_rst_in_tready", 64'(in_tready), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h40 + i), i == 3, hs);
      tile_q.push_back({i == 3, 32'(8'h40 + i)});
    end
    expect_tile();
    wait_out(4 * NPASS);
    repeat (20) @(posedge clk);
    #1;
    check_stream("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
